ft245r_tx_fifo: RTL and testbench
=================================

Name: ft245r_tx_fifo

Overview:
- Transmit-side companion to the FT245R receive path: streams signed 8-bit I/Q sample pairs to the host through the FT245R parallel FIFO write interface.
- Samples enter on a valid/ready handshake and are buffered in an internal byte FIFO, I byte first, then Q.
- A write engine paces WR strobes against TXE# with cycle-programmable setup, pulse, hold and recovery timing.
- Drives the shared USB data bus through an output-enable; the tristate buffer lives at top level.

Parameters:
- FIFO_DEPTH, 16: byte FIFO depth; power of two, >=4.
- SETUP_CLKS, 2: cycles data is driven before WR rises (>=20 ns at 50 MHz).
- PULSE_CLKS, 3: cycles WR is held high (>=50 ns).
- HOLD_CLKS, 1: cycles data stays driven after WR falls.
- RECOVER_CLKS, 4: idle cycles after hold before TXE# is re-evaluated; covers the synchronizer latency plus the FT245R TXE# rise.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_in  in  8  signed I sample.
- q_in  in  8  signed Q sample.
- s_valid  in  1  sample pair valid.
- s_ready  out  1  pair accepted when s_valid && s_ready.
- txe_  in  1  FT245R TXE#, asynchronous; low means a write is allowed.
- wr  out  1  FT245R WR strobe; data is latched on its falling edge.
- usbdata_out  out  8  data to the bus.
- usbdata_oe  out  1  bus drive enable.
- busy  out  1  write engine not in IDLE.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  bytes held.

Behaviour:
- Reset values, applied on the edge where rst is high: wr=0, usbdata_oe=0, usbdata_out=0, busy=0, FIFO flushed (level=0), state=IDLE, all counters 0.
- s_ready is combinational: (FIFO_DEPTH - fifo_level) >= 2, using the registered level. With level 0 during reset, s_ready=1.
- Accepting a pair writes i_in at tail and q_in at tail+1 in one cycle; level increases by 2. Pairs are never split.
- txe_ passes through a 2-flop synchronizer to give txe_s. All engine decisions use txe_s only.
- Engine states, with S/P/H/R = SETUP/PULSE/HOLD/RECOVER_CLKS:
  - IDLE: when level>0 and txe_s==0, load usbdata_out from the FIFO head, pop it, assert usbdata_oe and busy, go SETUP. Otherwise stay in IDLE.
  - SETUP: lasts S cycles, wr=0, oe=1. Then go STROBE.
  - STROBE: lasts P cycles, wr=1, data stable. Then go HOLD; wr falls on entry.
  - HOLD: lasts H cycles, wr=0, oe=1. Then go RECOVER.
  - RECOVER: lasts R cycles, oe=0, usbdata_out retains its value. Then go IDLE.
- Latency: from the IDLE decision cycle t, wr is high for cycles t+S+1 .. t+S+P. Back-to-back byte period is 1+S+P+H+R cycles (11 with defaults).
- A txe_ change after the IDLE decision is ignored; the transaction always completes.
- Byte order on the bus is strictly I,Q,I,Q... as accepted.
- Push and pop in the same cycle: level changes by +1. A push is judged on the pre-pop level, so no same-cycle forwarding credit is given.
- Empty FIFO: engine stays in IDLE, wr=0, oe=0.
- Full (fewer than 2 free bytes): s_ready=0. No data is lost and there is no overflow path.
- Reset mid-transaction: wr and oe drop on the reset edge, and any pulse in progress is truncated. Byte loss is accepted; the FIFO is flushed and pair alignment restarts with I.
- Pointers wrap modulo FIFO_DEPTH. Level saturates only by construction; it never exceeds FIFO_DEPTH.

Test Plan:
- Single pair i=0x7F, q=0x81 with txe_=0: usbdata shows 0x7F then 0x81. wr high exactly 3 cycles each. The wr rising edges are 11 cycles apart. oe is low during RECOVER. Level returns to 0.
- txe_=1 held while pushing 8 pairs into a 16-deep FIFO: level reaches 16 and s_ready=0 on the 9th offer. Releasing txe_=0 drains 16 bytes in order, and s_ready returns to 1 once level<=14.
- txe_ pulsed high for 1 cycle mid-STROBE: the current byte completes unchanged. txe_ held high through RECOVER: the engine waits in IDLE with no wr.
- Continuous s_valid with txe_=0: simultaneous push and pop gives level +1 per accepted pair per pop cycle, with no dropped or reordered bytes over 100 pairs of an incrementing pattern.
- rst asserted on the 2nd STROBE cycle: wr=0 and oe=0 on the next edge, level=0. The next pair pushed emits its I byte first.
- Sign extremes i=0x80, q=0x00, then i=0x00, q=0x7F: bytes appear verbatim on usbdata_out in order.

Source files
------------

// File: rtl/ft245r_tx_fifo_if.sv
// Sample stream and FT245R bus signals of the transmit FIFO.
//
// Sample handshake: a pair {i_in, q_in} transfers on a rising clk edge
// where s_valid && s_ready. The source holds i_in/q_in/s_valid stable
// until that edge. s_ready depends only on registered state, so there is
// no combinational path from s_valid to s_ready.
interface ft245r_tx_fifo_if;
  logic [7:0] i_in;
  logic [7:0] q_in;
  logic       s_valid;
  logic       s_ready;
  logic       txe_;
  logic       wr;
  logic [7:0] usbdata_out;
  logic       usbdata_oe;

  // Environment side: sample source plus the FT245R TXE# pin.
  modport master (
    output i_in, q_in, s_valid, txe_,
    input  s_ready, wr, usbdata_out, usbdata_oe
  );

  // Transmit FIFO side.
  modport slave (
    input  i_in, q_in, s_valid, txe_,
    output s_ready, wr, usbdata_out, usbdata_oe
  );
endinterface

// File: rtl/ft245r_tx_fifo.sv
// FT245R transmit path: buffers signed I/Q pairs as bytes (I first, then Q)
// and writes them to the FT245R parallel FIFO with programmable
// setup/pulse/hold/recovery timing paced by the synchronized TXE#.
// The tristate buffer on the USB data bus lives at top level; this block
// only provides usbdata_out and usbdata_oe.
// All *_CLKS parameters must be in 1..256; FIFO_DEPTH a power of two >= 4.
module ft245r_tx_fifo #(
  parameter int FIFO_DEPTH   = 16,
  parameter int SETUP_CLKS   = 2,
  parameter int PULSE_CLKS   = 3,
  parameter int HOLD_CLKS    = 1,
  parameter int RECOVER_CLKS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  ft245r_tx_fifo_if.slave               bus,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [2:0]                    o_dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_STROBE  = 3'd2;
  localparam logic [2:0] ST_HOLD    = 3'd3;
  localparam logic [2:0] ST_RECOVER = 3'd4;

  // Highest level at which a whole pair still fits.
  localparam logic [LW-1:0] LVL_PUSH_MAX = LW'(FIFO_DEPTH - 2);

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [LW-1:0] r_level;

  logic          r_txe_meta;
  logic          r_txe_s;

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_wr;
  logic          r_oe;
  logic [7:0]    r_data;

  logic          w_push;
  logic          w_pop;
  logic [AW-1:0] w_tail_p1;
  logic [CW-1:0] w_last;
  logic          w_cnt_done;

  // A pair is accepted only if both bytes fit, judged on the registered
  // level; a pop in the same cycle does not lend its slot to the push.
  assign bus.s_ready = (r_level <= LVL_PUSH_MAX);
  assign w_push      = bus.s_valid && bus.s_ready;
  assign w_pop       = (r_state == ST_IDLE) && (r_level != '0) && !r_txe_s;
  assign w_tail_p1   = r_tail + AW'(1);

  // Two-flop synchronizer for the asynchronous TXE#; resets to "not writable".
  always_ff @(posedge clk) begin
    if (rst) begin
      r_txe_meta <= 1'b1;
      r_txe_s    <= 1'b1;
    end else begin
      r_txe_meta <= bus.txe_;
      r_txe_s    <= r_txe_meta;
    end
  end

  // Byte storage: an accepted pair lands at tail (I) and tail+1 (Q).
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tail]    <= bus.i_in;
      r_mem[w_tail_p1] <= bus.q_in;
    end
  end

  // FIFO pointers and level; the level can never pass FIFO_DEPTH because
  // pushes need two free bytes and pops need one held byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + AW'(2);
      if (w_pop)  r_head <= r_head + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(2);
        2'b01:   r_level <= r_level - LW'(1);
        2'b11:   r_level <= r_level + LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Last count value of the phase the engine is currently in.
  always_comb begin
    w_last = '0;
    case (r_state)
      ST_SETUP:   w_last = CW'(SETUP_CLKS - 1);
      ST_STROBE:  w_last = CW'(PULSE_CLKS - 1);
      ST_HOLD:    w_last = CW'(HOLD_CLKS - 1);
      ST_RECOVER: w_last = CW'(RECOVER_CLKS - 1);
      default:    w_last = '0;
    endcase
  end

  assign w_cnt_done = (r_cnt == w_last);

  // Write engine: IDLE decides on txe_s, then runs the fixed
  // SETUP/STROBE/HOLD/RECOVER sequence regardless of later TXE# changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_oe    <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_pop) begin
            r_data  <= r_mem[r_head];
            r_oe    <= 1'b1;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (w_cnt_done) begin
            r_cnt   <= '0;
            r_wr    <= 1'b1;
            r_state <= ST_STROBE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_STROBE: begin
          if (w_cnt_done) begin
            r_cnt   <= '0;
            r_wr    <= 1'b0;
            r_state <= ST_HOLD;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_HOLD: begin
          if (w_cnt_done) begin
            r_cnt   <= '0;
            r_oe    <= 1'b0;
            r_state <= ST_RECOVER;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_RECOVER: begin
          if (w_cnt_done) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_cnt   <= '0;
          r_wr    <= 1'b0;
          r_oe    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.wr          = r_wr;
  assign bus.usbdata_oe  = r_oe;
  assign bus.usbdata_out = r_data;
  assign busy            = (r_state != ST_IDLE);
  assign fifo_level      = r_level;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_ft245r_tx_fifo.sv
// Bench for ft245r_tx_fifo: a queue/timeline model predicts every output
// each cycle, and directed tests pin bus byte order and timing with literals.
module tb_ft245r_tx_fifo;

  localparam int DEPTH = 16;
  localparam int S     = 2;
  localparam int P     = 3;
  localparam int H     = 1;
  localparam int R     = 4;
  localparam int T     = 1 + S + P + H + R;
  localparam int LW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ft245r_tx_fifo_if bus ();
  logic          busy;
  logic [LW-1:0] fifo_level;
  logic [2:0]    dbg_state;

  ft245r_tx_fifo #(
    .FIFO_DEPTH(DEPTH), .SETUP_CLKS(S), .PULSE_CLKS(P),
    .HOLD_CLKS(H), .RECOVER_CLKS(R)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .busy       (busy),
    .fifo_level (fifo_level),
    .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Byte queue plus the start cycle of the current bus write; outputs are
  // derived from the phase offset within the 1+S+P+H+R byte period.
  logic [7:0] exp_q[$];
  int         m_cyc    = 0;
  bit         m_valid  = 1'b0;
  bit         m_active = 1'b0;
  int         m_start  = 0;
  logic [7:0] m_data   = 8'h00;
  logic       m_s1     = 1'b1;
  logic       m_s2     = 1'b1;

  function automatic bit m_idle();
    return !m_active || ((m_cyc - m_start) >= T);
  endfunction

  function automatic int m_phase();
    return m_active ? (m_cyc - m_start) : -1;
  endfunction

  always @(posedge clk) begin : model_step
    bit do_pop;
    bit do_push;
    if (rst) begin
      exp_q.delete();
      m_active = 1'b0;
      m_data   = 8'h00;
      m_s1     = 1'b1;
      m_s2     = 1'b1;
      m_valid  = 1'b1;
    end else if (m_valid) begin
      do_pop  = m_idle() && (exp_q.size() > 0) && !m_s2;
      do_push = bus.s_valid && ((DEPTH - exp_q.size()) >= 2);
      if (do_pop) begin
        m_data   = exp_q.pop_front();
        m_start  = m_cyc;
        m_active = 1'b1;
      end
      if (do_push) begin
        exp_q.push_back(bus.i_in);
        exp_q.push_back(bus.q_in);
      end
      m_s2 = m_s1;
      m_s1 = bus.txe_;
    end
    m_cyc++;
  end

  // ---------------- per-cycle compare and bus capture ----------------
  logic [7:0] obs_q[$];
  int         len_q[$];
  int         rise_q[$];
  logic       prev_wr = 1'b0;
  int         wr_len  = 0;

  always @(negedge clk) begin : compare
    int   ph;
    logic e_busy, e_wr, e_oe, e_rdy;
    if (m_valid) begin
      ph     = m_phase();
      e_busy = m_active && (ph >= 1) && (ph <= T - 1);
      e_wr   = m_active && (ph >= S + 1) && (ph <= S + P);
      e_oe   = m_active && (ph >= 1) && (ph <= S + P + H);
      e_rdy  = (DEPTH - exp_q.size()) >= 2;
      check("cycle_outputs{busy,wr,oe,rdy,data,level}",
            {12'h0, busy, bus.wr, bus.usbdata_oe, bus.s_ready, bus.usbdata_out, 8'(fifo_level)},
            {12'h0, e_busy, e_wr, e_oe, e_rdy, m_data, 8'(exp_q.size())});
      if (bus.wr && !prev_wr) rise_q.push_back(m_cyc);
      if (bus.wr) wr_len++;
      if (!bus.wr && prev_wr) begin
        obs_q.push_back(bus.usbdata_out);
        len_q.push_back(wr_len);
        wr_len = 0;
      end
      prev_wr = bus.wr;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_obs();
    obs_q.delete();
    len_q.delete();
    rise_q.delete();
  endtask

  // Leaves s_valid high on return so back-to-back calls stream.
  task automatic push_pair(input logic [7:0] i, input logic [7:0] q);
    bit rdy;
    int n;
    n = 0;
    bus.i_in    = i;
    bus.q_in    = q;
    bus.s_valid = 1'b1;
    forever begin
      rdy = bus.s_ready;
      @(negedge clk);
      n++;
      if (rdy) break;
      if (n > 2000) begin
        check("push_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && m_idle() && m_active)) begin
      tick(1);
      n++;
      if (n > 4000) begin
        check(name, 0, 1);
        break;
      end
    end
    tick(2);
  endtask

  task automatic wait_phase(input int ph, input string name);
    int n;
    n = 0;
    while (!(m_active && m_phase() == ph)) begin
      tick(1);
      n++;
      if (n > 500) begin
        check(name, 0, 1);
        break;
      end
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int bad;
    bus.i_in    = 8'h00;
    bus.q_in    = 8'h00;
    bus.s_valid = 1'b0;
    bus.txe_    = 1'b0;
    rst         = 1'b1;
    tick(3);

    // Reset state
    check("rst_wr", bus.wr, 0);
    check("rst_oe", bus.usbdata_oe, 0);
    check("rst_data", bus.usbdata_out, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_level", fifo_level, 0);
    check("rst_s_ready", bus.s_ready, 1);
    rst = 1'b0;

    // Test 1: single pair 0x7F/0x81 with TXE# low
    clear_obs();
    push_pair(8'h7F, 8'h81);
    bus.s_valid = 1'b0;
    wait_phase(S + P + H + 1, "t1_reach_recover");
    check("t1_oe_in_recover", bus.usbdata_oe, 0);
    check("t1_data_retained", bus.usbdata_out, 8'h7F);
    wait_drain("t1_drain_timeout");
    check("t1_byte_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      check("t1_byte0", obs_q[0], 8'h7F);
      check("t1_byte1", obs_q[1], 8'h81);
      check("t1_wr_len0", len_q[0], 3);
      check("t1_wr_len1", len_q[1], 3);
    end
    if (rise_q.size() == 2) check("t1_rise_spacing", rise_q[1] - rise_q[0], 11);
    check("t1_level_end", fifo_level, 0);

    // Test 2: fill with TXE# high, then drain in order
    clear_obs();
    bus.txe_ = 1'b1;
    tick(4);
    for (int k = 0; k < 8; k++) push_pair(8'(8'h20 + 2 * k), 8'(8'h21 + 2 * k));
    bus.i_in = 8'h30;
    bus.q_in = 8'h31;
    check("t2_level_full", fifo_level, 16);
    check("t2_ready_ninth", bus.s_ready, 0);
    bus.txe_ = 1'b0;
    push_pair(8'h30, 8'h31);
    bus.s_valid = 1'b0;
    wait_drain("t2_drain_timeout");
    check("t2_byte_count", obs_q.size(), 18);
    bad = 0;
    foreach (obs_q[j]) if (obs_q[j] !== 8'(8'h20 + j)) bad++;
    check("t2_order_errors", bad, 0);

    // Test 3: TXE# glitch mid-STROBE, then TXE# high through RECOVER
    clear_obs();
    push_pair(8'h5A, 8'hA5);
    bus.s_valid = 1'b0;
    wait_phase(S + 2, "t3_reach_strobe");
    bus.txe_ = 1'b1;
    tick(1);
    bus.txe_ = 1'b0;
    wait_phase(S + P + H + 1, "t3_reach_recover");
    bus.txe_ = 1'b1;
    tick(12);
    check("t3_wait_wr", bus.wr, 0);
    check("t3_wait_busy", busy, 0);
    check("t3_wait_level", fifo_level, 1);
    check("t3_first_count", obs_q.size(), 1);
    if (obs_q.size() == 1) check("t3_first_byte", obs_q[0], 8'h5A);
    bus.txe_ = 1'b0;
    wait_drain("t3_drain_timeout");
    check("t3_total_count", obs_q.size(), 2);
    if (obs_q.size() == 2) check("t3_second_byte", obs_q[1], 8'hA5);

    // Test 4: continuous stream of 100 pairs, incrementing bytes
    clear_obs();
    for (int k = 0; k < 100; k++) push_pair(8'(2 * k), 8'(2 * k + 1));
    bus.s_valid = 1'b0;
    wait_drain("t4_drain_timeout");
    check("t4_byte_count", obs_q.size(), 200);
    bad = 0;
    foreach (obs_q[j]) if (obs_q[j] !== 8'(j)) bad++;
    check("t4_order_errors", bad, 0);

    // Test 5: reset on the 2nd STROBE cycle
    clear_obs();
    push_pair(8'hC1, 8'hC2);
    push_pair(8'hC3, 8'hC4);
    bus.s_valid = 1'b0;
    wait_phase(S + 2, "t5_reach_strobe2");
    check("t5_wr_before_rst", bus.wr, 1);
    rst = 1'b1;
    tick(1);
    check("t5_wr_after_rst", bus.wr, 0);
    check("t5_oe_after_rst", bus.usbdata_oe, 0);
    check("t5_level_after_rst", fifo_level, 0);
    rst = 1'b0;
    tick(1);
    clear_obs();
    push_pair(8'h11, 8'h22);
    bus.s_valid = 1'b0;
    wait_drain("t5_drain_timeout");
    check("t5_byte_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      check("t5_byte0_is_i", obs_q[0], 8'h11);
      check("t5_byte1_is_q", obs_q[1], 8'h22);
    end

    // Test 6: sign extremes pass verbatim
    clear_obs();
    push_pair(8'h80, 8'h00);
    push_pair(8'h00, 8'h7F);
    bus.s_valid = 1'b0;
    wait_drain("t6_drain_timeout");
    check("t6_byte_count", obs_q.size(), 4);
    if (obs_q.size() == 4) begin
      check("t6_byte0", obs_q[0], 8'h80);
      check("t6_byte1", obs_q[1], 8'h00);
      check("t6_byte2", obs_q[2], 8'h00);
      check("t6_byte3", obs_q[3], 8'h7F);
    end

    // Final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
